time_counter: RTL and testbench



---
 rtl/time_counter.sv | 157 +++++++++++++++
 tb/tb_time_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// time_counter: BCD hours:minutes:seconds time-of-day core.
//   - clk_1Hz is edge-detected in the sys_clk domain to produce a one-cycle tick.
//   - A three-state mode FSM (RUN -> SET_HOUR -> SET_MIN -> RUN) lets the user
//     set hours and minutes with single-cycle key pulses.
//   - Optional feature macro: HOURLY_CHIME_EN adds the registered hourly chime;
//     without it, chime is tied low.
// Key inputs are single-cycle pulses that are already debounced; there is no
// valid/ready handshake.
// A key pulse is acted on at the edge that samples it.
module time_counter #(
  parameter int HOUR_MAX = 23
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       day_pulse,
  output logic       chime
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  localparam logic [7:0] MIN_SEC_MAX  = 8'h59;

  // One BCD field increment.
  //   Result bit [8]   is the wrap/carry out.
  //   Result bits [7:0] hold the new field value.
  // A field at (or somehow above) its maximum wraps to 00.
  // A units digit of 9 (or above) rolls into the tens digit.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [8:0] r;
    if (v >= max) begin
      r = {1'b1, 8'h00};
    end else if (v[3:0] >= 4'd9) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  mode_e      state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       clk_1hz_d_q;
  logic       day_pulse_q, day_pulse_d;
  logic       tick;
  logic [8:0] sec_inc, min_inc, hour_inc;

  assign tick = clk_1Hz & ~clk_1hz_d_q;

  // Next-state: mode FSM plus the time count. A mode key beats an inc key;
  // in RUN a tick and a mode key on the same edge both take effect.
  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    day_pulse_d = 1'b0;
    sec_inc     = bcd_inc(sec_q, MIN_SEC_MAX);
    min_inc     = bcd_inc(min_q, MIN_SEC_MAX);
    hour_inc    = bcd_inc(hour_q, HOUR_MAX_BCD);
    case (state_q)
      MODE_SET_HOUR: begin
        if (key_mode) begin
          state_d = MODE_SET_MIN;
        end else if (key_inc) begin
          hour_d = hour_inc[7:0];
        end
      end
      MODE_SET_MIN: begin
        if (key_mode) begin
          state_d = MODE_RUN;
          sec_d   = 8'h00;
        end else if (key_inc) begin
          min_d = min_inc[7:0];
        end
      end
      default: begin
        // RUN, and the unreachable encoding 11 which behaves as RUN and
        // is steered back to a legal state.
        if (tick) begin
          sec_d = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_d = min_inc[7:0];
            if (min_inc[8]) begin
              hour_d      = hour_inc[7:0];
              day_pulse_d = hour_inc[8];
            end
          end
        end
        state_d = key_mode ? MODE_SET_HOUR : MODE_RUN;
      end
    endcase
  end

  // State, count and tick-detector registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= MODE_RUN;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      clk_1hz_d_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      clk_1hz_d_q <= clk_1Hz;
      day_pulse_q <= day_pulse_d;
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_q, chime_d;

  // Chime decode on the next count so it changes on the same edge as the time.
  always_comb begin
    chime_d = (state_d == MODE_RUN) &&
              (((min_d == 8'h59) && (sec_d >= 8'h55)) ||
               ((min_d == 8'h00) && (sec_d == 8'h00)));
  end

  // Chime register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= chime_d;
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign mode      = state_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed bench for time_counter (HOUR_MAX = 23).
// Chime expectations follow HOURLY_CHIME_EN the same way as the design.
module tb_time_counter;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_1Hz = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       day_pulse, chime;

  int errors = 0;
  int checks = 0;

  time_counter #(.HOUR_MAX(23)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clk_1Hz  (clk_1Hz),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .mode     (mode),
    .day_pulse(day_pulse),
    .chime    (chime)
  );

  // Clock
  always #5 sys_clk = ~sys_clk;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_mode = 1'b0; key_inc = 1'b0; clk_1Hz = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic press_mode();
    key_mode = 1'b1; step(); key_mode = 1'b0;
  endtask

  task automatic press_inc();
    key_inc = 1'b1; step(); key_inc = 1'b0;
  endtask

  // Rising clk_1Hz sampled at one edge; clk_1Hz left low afterwards.
  task automatic tick_edge();
    clk_1Hz = 1'b1; step(); clk_1Hz = 1'b0;
  endtask

  task automatic tick();
    tick_edge(); step();
  endtask

  // Reset, then set hh:mm through the key interface; ends in RUN at hh:mm:00.
  task automatic preset(input int h, input int m);
    do_reset();
    press_mode();
    for (int i = 0; i < h; i++) press_inc();
    press_mode();
    for (int i = 0; i < m; i++) press_inc();
    press_mode();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_mode = 1'($urandom_range(0, 1));
      key_inc  = 1'($urandom_range(0, 1));
      clk_1Hz  = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; key_mode = 1'b0; key_inc = 1'b0; clk_1Hz = 1'b0;
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      errors++; $display("FAIL reset_time got %h:%h:%h exp 00:00:00", hour_bcd, min_bcd, sec_bcd);
    end
    checks++;
    if ({mode, day_pulse, chime} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got mode=%b day=%b chime=%b exp 00/0/0", mode, day_pulse, chime);
    end
  endtask

  // clk_1Hz high at reset release yields a tick on the first free edge;
  // a reset edge overrides an in-flight tick.
  task automatic test_reset_tick();
    preset(1, 2);
    tick(); tick();
    rst = 1'b1; clk_1Hz = 1'b1; key_inc = 1'b1;
    step();
    rst = 1'b0; key_inc = 1'b0;
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      errors++; $display("FAIL reset_override got %h:%h:%h exp 00:00:00", hour_bcd, min_bcd, sec_bcd);
    end
    step();
    clk_1Hz = 1'b0;
    checks++;
    if (sec_bcd !== 8'h01) begin
      errors++; $display("FAIL reset_release_tick got sec=%h exp 01", sec_bcd);
    end
    step();
    checks++;
    if (sec_bcd !== 8'h01) begin
      errors++; $display("FAIL level_not_retick got sec=%h exp 01", sec_bcd);
    end
  endtask

  task automatic test_ripple();
    logic legal;
    preset(9, 59);
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd, mode} !== {24'h095900, 2'b00}) begin
      errors++; $display("FAIL preset got %h:%h:%h mode=%b exp 09:59:00 mode=00", hour_bcd, min_bcd, sec_bcd, mode);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      legal = (sec_bcd[3:0] <= 4'd9) && (sec_bcd[7:4] <= 4'd5) &&
              (min_bcd[3:0] <= 4'd9) && (min_bcd[7:4] <= 4'd5) &&
              (hour_bcd[3:0] <= 4'd9) && (hour_bcd <= 8'h23);
      checks++;
      if (!legal) begin
        errors++; $display("FAIL bcd_legal step %0d got %h:%h:%h", i, hour_bcd, min_bcd, sec_bcd);
      end
    end
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h100000) begin
      errors++; $display("FAIL ripple got %h:%h:%h exp 10:00:00", hour_bcd, min_bcd, sec_bcd);
    end
    tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h100001) begin
      errors++; $display("FAIL ripple_next got %h:%h:%h exp 10:00:01", hour_bcd, min_bcd, sec_bcd);
    end
  endtask

  task automatic test_midnight();
    preset(23, 59);
    for (int i = 0; i < 59; i++) tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd, day_pulse} !== {24'h235959, 1'b0}) begin
      errors++; $display("FAIL pre_midnight got %h:%h:%h day=%b exp 23:59:59 day=0", hour_bcd, min_bcd, sec_bcd, day_pulse);
    end
    tick_edge();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd, day_pulse} !== {24'h000000, 1'b1}) begin
      errors++; $display("FAIL midnight got %h:%h:%h day=%b exp 00:00:00 day=1", hour_bcd, min_bcd, sec_bcd, day_pulse);
    end
    step();
    checks++;
    if (day_pulse !== 1'b0) begin
      errors++; $display("FAIL day_pulse_width got %b exp 0", day_pulse);
    end
  endtask

  task automatic test_set_mode();
    preset(12, 34);
    for (int i = 0; i < 56; i++) tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123456) begin
      errors++; $display("FAIL set_start got %h:%h:%h exp 12:34:56", hour_bcd, min_bcd, sec_bcd);
    end
    press_mode();
    for (int i = 0; i < 15; i++) press_inc();
    checks++;
    if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'b01, 24'h033456}) begin
      errors++; $display("FAIL set_hour got mode=%b %h:%h:%h exp 01 03:34:56", mode, hour_bcd, min_bcd, sec_bcd);
    end
    tick();
    checks++;
    if (sec_bcd !== 8'h56) begin
      errors++; $display("FAIL set_hour_tick got sec=%h exp 56", sec_bcd);
    end
    press_mode();
    for (int i = 0; i < 26; i++) press_inc();
    checks++;
    if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'b10, 24'h030056}) begin
      errors++; $display("FAIL set_min got mode=%b %h:%h:%h exp 10 03:00:56", mode, hour_bcd, min_bcd, sec_bcd);
    end
    press_mode();
    checks++;
    if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'b00, 24'h030000}) begin
      errors++; $display("FAIL set_exit got mode=%b %h:%h:%h exp 00 03:00:00", mode, hour_bcd, min_bcd, sec_bcd);
    end
    press_inc();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h030000) begin
      errors++; $display("FAIL run_inc_ignored got %h:%h:%h exp 03:00:00", hour_bcd, min_bcd, sec_bcd);
    end
  endtask

  task automatic test_collisions();
    preset(5, 10);
    press_mode();
    key_mode = 1'b1; key_inc = 1'b1; step(); key_mode = 1'b0; key_inc = 1'b0;
    checks++;
    if ({mode, hour_bcd} !== {2'b10, 8'h05}) begin
      errors++; $display("FAIL mode_beats_inc got mode=%b hour=%h exp 10/05", mode, hour_bcd);
    end
    tick();
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h1000) begin
      errors++; $display("FAIL set_min_tick got %h:%h exp 10:00", min_bcd, sec_bcd);
    end
    press_mode();
    clk_1Hz = 1'b1; key_mode = 1'b1; step(); clk_1Hz = 1'b0; key_mode = 1'b0;
    checks++;
    if ({mode, sec_bcd} !== {2'b01, 8'h01}) begin
      errors++; $display("FAIL tick_with_mode got mode=%b sec=%h exp 01/01", mode, sec_bcd);
    end
  endtask

  task automatic test_chime();
    logic [7:0] exp_chime;
    preset(7, 59);
    for (int i = 0; i < 54; i++) tick();
    // Expected chime for 07:59:54, :55 .. :59, 08:00:00, 08:00:01.
`ifdef HOURLY_CHIME_EN
    exp_chime = 8'b01111110;
`else
    exp_chime = 8'b00000000;
`endif
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (chime !== exp_chime[7 - i]) begin
        errors++; $display("FAIL chime at %h:%h:%h got %b exp %b", hour_bcd, min_bcd, sec_bcd, chime, exp_chime[7 - i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_tick();
    test_ripple();
    test_midnight();
    test_set_mode();
    test_collisions();
    test_chime();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
